// File: rtl/alu_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_serial                                                    |
// | Brief    : Digit-serial add/subtract ALU (ADD, SUB, PASSB, INCB) with a  |
// |            start/done handshake, registered result and NZCV flags.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  // Number of compute cycles and the counter that walks through them.
  localparam int            N    = WIDTH / DIGIT;
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Operands must split into whole digits.
  generate
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("alu_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;         // operand A shift register
  logic [WIDTH-1:0]  b_q, b_d;         // operand B shift register
  logic [WIDTH-1:0]  acc_q, acc_d;     // sum bits collected from the top
  logic              carry_q, carry_d; // carry held between digits
  logic [CW-1:0]     count_q, count_d;
  logic              aen_q, aen_d;     // A enable (0 forces A to zero)
  logic              binv_q, binv_d;   // invert B
  logic [WIDTH-1:0]  result_q, result_d;
  logic              fn_q, fn_d;
  logic              fz_q, fz_d;
  logic              fc_q, fc_d;
  logic              fv_q, fv_d;

  logic [DIGIT-1:0]  a_dig;
  logic [DIGIT-1:0]  b_dig;
  logic [DIGIT-1:0]  sum_dig;
  logic              carry_out;
  logic              carry_msb;
  logic [WIDTH-1:0]  acc_shift;

  // Ripple slice: one DIGIT-wide add of the low operand bits plus held carry.
  always_comb begin : slice
    logic [DIGIT:0] rc;
    a_dig   = aen_q ? a_q[DIGIT-1:0] : '0;
    b_dig   = binv_q ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    rc      = '0;
    rc[0]   = carry_q;
    sum_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum_dig[i] = a_dig[i] ^ b_dig[i] ^ rc[i];
      rc[i+1]    = (a_dig[i] & b_dig[i]) | (rc[i] & (a_dig[i] ^ b_dig[i]));
    end
    carry_out = rc[DIGIT];
    // On the final digit this is the carry into bit WIDTH-1 of the word.
    carry_msb = rc[DIGIT-1];
  end

  // New sum digit enters at the top; after N shifts the word is aligned.
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));

  // Next-state and datapath update for IDLE / RUN / DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    count_d  = count_q;
    aen_d    = aen_q;
    binv_d   = binv_q;
    result_d = result_q;
    fn_d     = fn_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start too, giving back-to-back operation.
        if (start) begin
          a_d     = a;
          b_d     = b;
          aen_d   = ~op[1];
          binv_d  = ~op[1] & op[0];
          carry_d = op[0];
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = carry_out;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d  = S_DONE;
          result_d = acc_shift;
          fn_d     = acc_shift[WIDTH-1];
          fz_d     = (acc_shift == '0);
          fc_d     = carry_out;
          fv_d     = carry_msb ^ carry_out;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      aen_q    <= 1'b0;
      binv_q   <= 1'b0;
      result_q <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      aen_q    <= aen_d;
      binv_q   <= binv_d;
      result_q <= result_d;
      fn_q     <= fn_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flag_n = fn_q;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign flag_v = fv_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_serial                                                 |
// | Brief    : Randomised self-checking bench for alu_serial, three          |
// |            configurations (16/1, 16/4, 8/8) against a word-level model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_serial;

  logic        clk;
  logic        reset;
  logic        start_s [3];
  logic [1:0]  op_s    [3];
  logic [15:0] a_s     [3];
  logic [15:0] b_s     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        fn_v    [3];
  logic        fz_v    [3];
  logic        fc_v    [3];
  logic        fv_v    [3];
  logic [15:0] res0, res1;
  logic [7:0]  res2;
  logic [15:0] res_s   [3];
  logic [3:0]  flg_s   [3];
  logic [15:0] prev_res [3];

  int n_checks = 0;
  int n_fail   = 0;

  alu_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start_s[0]), .op(op_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_v[0]), .done(done_v[0]),
    .result(res0), .flag_n(fn_v[0]), .flag_z(fz_v[0]), .flag_c(fc_v[0]),
    .flag_v(fv_v[0])
  );

  alu_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start_s[1]), .op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_v[1]), .done(done_v[1]),
    .result(res1), .flag_n(fn_v[1]), .flag_z(fz_v[1]), .flag_c(fc_v[1]),
    .flag_v(fv_v[1])
  );

  alu_serial #(.WIDTH(8), .DIGIT(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start_s[2]), .op(op_s[2]),
    .a(a_s[2][7:0]), .b(b_s[2][7:0]), .busy(busy_v[2]), .done(done_v[2]),
    .result(res2), .flag_n(fn_v[2]), .flag_z(fz_v[2]), .flag_c(fc_v[2]),
    .flag_v(fv_v[2])
  );

  assign res_s[0] = res0;
  assign res_s[1] = res1;
  assign res_s[2] = {8'h00, res2};
  assign flg_s[0] = {fn_v[0], fz_v[0], fc_v[0], fv_v[0]};
  assign flg_s[1] = {fn_v[1], fz_v[1], fc_v[1], fv_v[1]};
  assign flg_s[2] = {fn_v[2], fz_v[2], fc_v[2], fv_v[2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  function automatic int wd(input int k);
    return (k == 2) ? 8 : 16;
  endfunction

  function automatic int ncyc(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 1;
  endfunction

  // Word-level reference: {result[15:0], N, Z, C, V}.
  function automatic logic [19:0] model(input int w, input logic [1:0] o,
                                        input logic [15:0] aa, input logic [15:0] bb);
    logic [63:0] mask, mlow, av, bv, full, low, r;
    logic n, z, c, v;
    mask = (64'd1 << w) - 64'd1;
    mlow = (64'd1 << (w - 1)) - 64'd1;
    av   = o[1] ? 64'd0 : ({48'd0, aa} & mask);
    bv   = (o == 2'b01) ? ({48'd0, ~bb} & mask) : ({48'd0, bb} & mask);
    full = av + bv + {63'd0, o[0]};
    low  = (av & mlow) + (bv & mlow) + {63'd0, o[0]};
    r    = full & mask;
    n    = r[w-1];
    z    = (r == 64'd0);
    c    = full[w];
    v    = low[w-1] ^ c;
    return {r[15:0], n, z, c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(input int k, output int lat, output int bc);
    lat = 0;
    bc  = busy_v[k] ? 1 : 0;
    while (!done_v[k] && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy_v[k]) bc++;
    end
  endtask

  task automatic do_op(input int k, input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb);
    logic [19:0] e;
    int lat, bc;
    e = model(wd(k), o, aa, bb);
    start_s[k] = 1'b1; op_s[k] = o; a_s[k] = aa; b_s[k] = bb;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    a_s[k] = 16'($urandom); b_s[k] = 16'($urandom); op_s[k] = 2'($urandom);
    check($sformatf("hold_result.k%0d", k), res_s[k], prev_res[k]);
    wait_done(k, lat, bc);
    check($sformatf("latency.k%0d", k), lat, ncyc(k));
    check($sformatf("busy_cycles.k%0d", k), bc, ncyc(k));
    check($sformatf("result.k%0d op%0d a=%h b=%h", k, o, aa, bb), res_s[k], e[19:4]);
    check($sformatf("flags_nzcv.k%0d op%0d a=%h b=%h", k, o, aa, bb), flg_s[k], e[3:0]);
    prev_res[k] = e[19:4];
    @(posedge clk); #1;
    check($sformatf("done_one_cycle.k%0d", k), done_v[k], 0);
    check($sformatf("idle_after.k%0d", k), busy_v[k], 0);
  endtask

  initial begin
    logic [19:0] e1, e2;
    int lat, bc, pulses;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; op_s[k] = 2'b00; a_s[k] = '0; b_s[k] = '0; prev_res[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_busy.k%0d", k), busy_v[k], 0);
      check($sformatf("reset_done.k%0d", k), done_v[k], 0);
      check($sformatf("reset_result.k%0d", k), res_s[k], 0);
      check($sformatf("reset_flags.k%0d", k), flg_s[k], 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    do_op(0, 2'b00, 16'h7FFF, 16'h0001);
    do_op(0, 2'b01, 16'h0005, 16'h0005);
    do_op(0, 2'b01, 16'h0003, 16'h0005);
    do_op(0, 2'b01, 16'h8000, 16'h0001);
    do_op(0, 2'b11, 16'h1234, 16'hFFFF);
    do_op(0, 2'b10, 16'hAAAA, 16'h00F0);
    do_op(1, 2'b00, 16'hFFFF, 16'h0001);
    do_op(2, 2'b01, 16'h0000, 16'h0001);

    // Start during RUN is ignored and not queued.
    e1 = model(16, 2'b00, 16'h1111, 16'h2222);
    start_s[0] = 1'b1; op_s[0] = 2'b00; a_s[0] = 16'h1111; b_s[0] = 16'h2222;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start_s[0] = 1'b1; op_s[0] = 2'b01; a_s[0] = 16'hFFFF; b_s[0] = 16'h0001;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_done(0, lat, bc);
    check("ignored_start_latency", 5 + lat, 16);
    check("ignored_start_result", res_s[0], e1[19:4]);
    check("ignored_start_flags", flg_s[0], e1[3:0]);
    repeat (3) begin @(posedge clk); #1; end
    check("ignored_start_not_queued", busy_v[0], 0);

    // Back-to-back: start held high into DONE.
    e1 = model(16, 2'b01, 16'h0003, 16'h0005);
    e2 = model(16, 2'b01, 16'h8000, 16'h0001);
    start_s[0] = 1'b1; op_s[0] = 2'b01; a_s[0] = 16'h0003; b_s[0] = 16'h0005;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    start_s[0] = 1'b1; op_s[0] = 2'b01; a_s[0] = 16'h8000; b_s[0] = 16'h0001;
    @(posedge clk); #1;
    check("b2b_first_done", done_v[0], 1);
    check("b2b_first_result", res_s[0], e1[19:4]);
    check("b2b_first_flags", flg_s[0], e1[3:0]);
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    check("b2b_restart_busy", busy_v[0], 1);
    wait_done(0, lat, bc);
    check("b2b_done_gap", 1 + lat, 17);
    check("b2b_second_result", res_s[0], e2[19:4]);
    check("b2b_second_flags", flg_s[0], e2[3:0]);
    @(posedge clk); #1;

    // Reset mid-RUN aborts with no done pulse.
    start_s[0] = 1'b1; op_s[0] = 2'b00; a_s[0] = 16'h1234; b_s[0] = 16'h1111;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy_v[0], 0);
    check("abort_done", done_v[0], 0);
    check("abort_result", res_s[0], 0);
    check("abort_flags", flg_s[0], 0);
    for (int k = 0; k < 3; k++) prev_res[k] = '0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_op(0, 2'b00, 16'h0002, 16'h0003);

    // Randomised operations with edge-value bias.
    for (int i = 0; i < 12; i++)
      do_op(0, 2'($urandom_range(0, 3)),
            (i % 4 == 0) ? 16'hFFFF : 16'($urandom),
            (i % 5 == 0) ? 16'h8000 : 16'($urandom));
    for (int i = 0; i < 25; i++)
      do_op(1, 2'($urandom_range(0, 3)), 16'($urandom), (i % 6 == 0) ? 16'hFFFF : 16'($urandom));
    for (int i = 0; i < 25; i++)
      do_op(2, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 255)),
            (i % 7 == 0) ? 16'h00FF : 16'($urandom_range(0, 255)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised multi-cycle add/subtract ALU for the MU0 datapath; next generation of the 1-bit full-adder cell.
- Processes WIDTH-bit operands DIGIT bits per clock through a ripple slice with A-enable and B-invert control, holding the carry between cycles.
- Serves A+B, A-B, pass-B and B+1, the MU0 ALU function set.
- Start/done handshake, result register and NZCV flags.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 1, bits processed per clock. WIDTH mod DIGIT must be 0, otherwise elaboration fails.
- N, WIDTH/DIGIT (derived, not overridable), number of compute cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- op  in  2  00 ADD (A+B), 01 SUB (A-B), 10 PASSB (B), 11 INCB (B+1); sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when result and flags are valid
- result  out  WIDTH  registered result
- flag_n  out  1  result[WIDTH-1]
- flag_z  out  1  result == 0
- flag_c  out  1  final carry out; for SUB, 1 means no borrow
- flag_v  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock, synchronous active-high reset.
- Reset: state=IDLE; busy=0, done=0, result=0, all flags 0, internal shift registers, count and carry cleared. Reset has priority over every other input in every state.
- Reset asserted mid-RUN aborts the operation. The partial result is discarded and no done pulse follows.

Control, per op:
- ADD: aen=1, binv=0, cin=0
- SUB: aen=1, binv=1, cin=1
- PASSB: aen=0, binv=0, cin=0
- INCB: aen=0, binv=0, cin=1

State machine (IDLE, RUN, DONE):
- IDLE: on start=1, capture a, b and op, set carry=cin and count=0, go to RUN. Otherwise stay.
- RUN: busy=1.
  - Each edge adds the low DIGIT bits of the A and B shift registers (with aen/binv applied) plus carry.
  - Shift the DIGIT sum bits into the top of the result shift register, shift A and B right by DIGIT, update carry, increment count.
  - On the edge where count==N-1 goes to N, go to DONE and load result and flags.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
  - start=1 in DONE is accepted (back-to-back) and goes straight to RUN; done is still 1 in that cycle.
- start while busy (RUN) is ignored and not queued. Operand or op changes during RUN have no effect.

Timing and register rules:
- Latency: start sampled at edge k; RUN covers edges k+1..k+N; done is high in the cycle following edge k+N.
  - DIGIT=1, WIDTH=16: done 17 cycles after the start edge.
  - DIGIT=4: 5 cycles.
- result and flags update only on the transition into DONE. They hold until the next completed operation or reset; they are not cleared on start.
- Arithmetic is modulo 2^WIDTH. flag_v uses the carry into bit WIDTH-1 from the final digit's internal ripple; for DIGIT=1 that is the carry entering the last cycle.
- PASSB and INCB treat A as zero regardless of a. Flags are computed the same way for all ops.
- Wrap: INCB with b=all ones gives 0 with flag_c=1.

Test Plan:
- WIDTH=16, DIGIT=1, ADD a=0x7FFF b=0x0001 -> result=0x8000, N=1 Z=0 C=0 V=1; busy high 16 cycles; done exactly 17 cycles after the start edge, one cycle wide.
- SUB a=0x0005 b=0x0005 -> 0x0000, Z=1 C=1 N=0 V=0. SUB a=0x0003 b=0x0005 -> 0xFFFE, N=1 C=0 V=0. SUB a=0x8000 b=0x0001 -> 0x7FFF, V=1 C=1.
- INCB a=0x1234 b=0xFFFF -> 0x0000, Z=1 C=1. PASSB a=0xAAAA b=0x00F0 -> 0x00F0, all flags 0.
- start pulsed again 5 cycles into RUN with different operands -> ignored, first result delivered unchanged. start held high through DONE -> second operation begins, second done 17 cycles after the first.
- reset asserted at cycle 8 of RUN -> next edge busy=0, done=0, result=0, flags=0; no done pulse. A fresh ADD 0x0002+0x0003 then gives 0x0005.
- WIDTH=16, DIGIT=4: ADD 0xFFFF+0x0001 -> 0x0000, Z=1 C=1 V=0; done 5 cycles after start. WIDTH=8, DIGIT=8: SUB 0x00-0x01 -> 0xFF, N=1 C=0; done 2 cycles after start.
